// File: rtl/recon_step_scheduler_pkg.sv
// Shared types and constants for the intra-loop reconstructor.
// State encoding, frame block counts and enabler encodings.
package intra_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_FETCH,
    S_NPWAIT,
    S_PRED,
    S_WB,
    S_DONE
  } recon_state_t;

  localparam logic [2:0] EN_NONE    = 3'b000;
  localparam logic [2:0] EN_EXTRACT = 3'b001;
  localparam logic [2:0] EN_PREDICT = 3'b010;
  localparam logic [2:0] EN_WB      = 3'b100;

  function automatic int unsigned blk_count(
    input int unsigned w,
    input int unsigned l,
    input int unsigned e
  );
    return (w / e) * (l / e);
  endfunction

  localparam int unsigned NL = blk_count(1280, 720, 4);
  localparam int unsigned NC = blk_count(1280, 720, 8);

endpackage

// File: rtl/recon_step_scheduler_fb_collector.sv
// Sticky predadder done flags, step exit condition and PRED watchdog.
// A live pulse counts toward exit on the same cycle it arrives.
module fb_collector #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic in_pred,
  input  logic chroma_step,
  input  logic fb_luma4x4,
  input  logic fb_chromab8x8,
  input  logic fb_chromar8x8,
  output logic done,
  output logic expire
);

  localparam int unsigned WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  logic           f_l;
  logic           f_b;
  logic           f_r;
  logic           any_l;
  logic           any_b;
  logic           any_r;
  logic [WDW-1:0] wd;

  assign any_l = f_l | (in_pred & fb_luma4x4);
  assign any_b = f_b | (in_pred & fb_chromab8x8);
  assign any_r = f_r | (in_pred & fb_chromar8x8);

  assign done = in_pred & any_l
              & (~chroma_step | (any_b & any_r));

  // completion on the final watchdog cycle beats expiry
  assign expire = in_pred & (wd == WD_LAST) & ~done;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      f_l <= 1'b0;
      f_b <= 1'b0;
      f_r <= 1'b0;
    end else if (in_pred) begin
      f_l <= any_l;
      f_b <= any_b;
      f_r <= any_r;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr || !in_pred) begin
      wd <= '0;
    end else if (wd != WD_LAST) begin
      wd <= wd + 1'b1;
    end
  end

endmodule

// File: rtl/recon_step_scheduler.sv
// Frame-level step sequencer for the intra-loop reconstructor.
// One luma 4x4 per step; every 4th step adds the two chroma 8x8 blocks.
module recon_step_scheduler
  import intra_pkg::*;
#(
  parameter int unsigned WIDTH     = 1280,
  parameter int unsigned LENGTH    = 720,
  parameter int unsigned LUMA_MB   = 4,
  parameter int unsigned CHROMA_MB = 8,
  parameter int unsigned NP_LAT    = 1,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        blk_valid,
  output logic        blk_ready,
  input  logic        fb_luma4x4,
  input  logic        fb_chromab8x8,
  input  logic        fb_chromar8x8,
  output logic [2:0]  enabler,
  output logic [31:0] mbnumber_luma4x4,
  output logic [31:0] mbnumber_chroma,
  output logic        chroma_step,
  output logic        step_done,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout_err
);

  localparam int unsigned NUM_L = blk_count(WIDTH, LENGTH, LUMA_MB);
  localparam int unsigned NUM_C = blk_count(WIDTH, LENGTH, CHROMA_MB);
  localparam logic [31:0] LAST_L = 32'(NUM_L - 1);
  localparam int unsigned NPW = (NP_LAT > 1) ? $clog2(NP_LAT) : 1;
  localparam logic [NPW-1:0] NP_LAST = NPW'(NP_LAT - 1);

  // chroma blocks must tile the frame at one per four luma steps
  if (NUM_C * 4 != NUM_L) begin : g_geom_chk
    $error("chroma/luma block counts inconsistent");
  end

  recon_state_t   state;
  recon_state_t   state_nx;
  logic [31:0]    luma_cnt;
  logic [31:0]    chroma_cnt;
  logic [NPW-1:0] np_cnt;
  logic           in_pred;
  logic           fb_clr;
  logic           fb_done;
  logic           fb_expire;
  logic           active;

  assign in_pred = (state == S_PRED);
  assign fb_clr  = (state == S_FETCH) | abort;
  assign active  = (state != S_IDLE) && (state != S_DONE);

  assign chroma_step      = active && (luma_cnt[1:0] == 2'b00);
  assign mbnumber_luma4x4 = luma_cnt;
  assign mbnumber_chroma  = chroma_cnt;

  fb_collector #(
    .TIMEOUT(TIMEOUT)
  ) u_fb (
    .clk          (clk),
    .reset        (reset),
    .clr          (fb_clr),
    .in_pred      (in_pred),
    .chroma_step  (chroma_step),
    .fb_luma4x4   (fb_luma4x4),
    .fb_chromab8x8(fb_chromab8x8),
    .fb_chromar8x8(fb_chromar8x8),
    .done         (fb_done),
    .expire       (fb_expire)
  );

  always_comb begin
    state_nx   = state;
    enabler    = EN_NONE;
    blk_ready  = 1'b0;
    step_done  = 1'b0;
    frame_done = 1'b0;
    busy       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_READY;
      end
      S_READY: begin
        busy      = 1'b1;
        blk_ready = 1'b1;
        if (blk_valid) state_nx = S_FETCH;
      end
      S_FETCH: begin
        busy     = 1'b1;
        enabler  = EN_EXTRACT;
        state_nx = S_NPWAIT;
      end
      S_NPWAIT: begin
        busy = 1'b1;
        if (np_cnt == NP_LAST) state_nx = S_PRED;
      end
      S_PRED: begin
        busy    = 1'b1;
        enabler = EN_PREDICT;
        if (fb_done)        state_nx = S_WB;
        else if (fb_expire) state_nx = S_IDLE;
      end
      S_WB: begin
        busy      = 1'b1;
        enabler   = EN_WB;
        step_done = 1'b1;
        state_nx  = (luma_cnt == LAST_L) ? S_DONE : S_READY;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      luma_cnt    <= '0;
      chroma_cnt  <= '0;
      np_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      state  <= state_nx;
      np_cnt <= (state == S_NPWAIT && !abort) ? np_cnt + 1'b1 : '0;
      if (abort) begin
        luma_cnt   <= '0;
        chroma_cnt <= '0;
      end else begin
        unique case (1'b1)
          (state == S_IDLE) && start: begin
            luma_cnt    <= '0;
            chroma_cnt  <= '0;
            timeout_err <= 1'b0;
          end
          (state == S_WB): begin
            luma_cnt <= luma_cnt + 32'd1;
            if (chroma_step) chroma_cnt <= chroma_cnt + 32'd1;
          end
          (state == S_DONE): begin
            luma_cnt   <= '0;
            chroma_cnt <= '0;
          end
          (state == S_PRED) && fb_expire: begin
            timeout_err <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_recon_step_scheduler.sv
// Directed table-driven bench for recon_step_scheduler on a 16x8 frame.
// Expected PRED lengths and counters are hand-derived per vector.
module tb_recon_step_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        blk_valid;
  logic        blk_ready;
  logic        fb_luma4x4;
  logic        fb_chromab8x8;
  logic        fb_chromar8x8;
  logic [2:0]  enabler;
  logic [31:0] mbnumber_luma4x4;
  logic [31:0] mbnumber_chroma;
  logic        chroma_step;
  logic        step_done;
  logic        busy;
  logic        frame_done;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  int sd_cnt = 0;
  int fd_cnt = 0;

  always #5 clk = ~clk;

  recon_step_scheduler #(
    .WIDTH    (16),
    .LENGTH   (8),
    .LUMA_MB  (4),
    .CHROMA_MB(8),
    .NP_LAT   (1),
    .TIMEOUT  (64)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .abort           (abort),
    .blk_valid       (blk_valid),
    .blk_ready       (blk_ready),
    .fb_luma4x4      (fb_luma4x4),
    .fb_chromab8x8   (fb_chromab8x8),
    .fb_chromar8x8   (fb_chromar8x8),
    .enabler         (enabler),
    .mbnumber_luma4x4(mbnumber_luma4x4),
    .mbnumber_chroma (mbnumber_chroma),
    .chroma_step     (chroma_step),
    .step_done       (step_done),
    .busy            (busy),
    .frame_done      (frame_done),
    .timeout_err     (timeout_err)
  );

  always @(negedge clk) begin
    if (step_done)  sd_cnt++;
    if (frame_done) fd_cnt++;
  end

  typedef struct {
    int          dl;
    int          db;
    int          dr;
    int          exp_pred;
    logic        cs;
    logic [31:0] exp_l;
    logic [31:0] exp_c;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // handshake one step and run through PRED; returns PRED cycle count
  task automatic do_step(input int dl, input int db, input int dr,
                         output int npred);
    int guard;
    blk_valid = 1'b1;
    guard = 0;
    while (!blk_ready && guard < 20) begin
      tick();
      guard++;
    end
    chk("ready_wait", {31'd0, blk_ready}, 32'd1);
    tick();
    blk_valid = 1'b0;
    chk("en_fetch", {29'd0, enabler}, 32'd1);
    tick();
    chk("en_npwait", {29'd0, enabler}, 32'd0);
    tick();
    npred = 0;
    while (enabler == 3'b010 && npred < 100) begin
      fb_luma4x4    = (npred == dl);
      fb_chromab8x8 = (npred == db);
      fb_chromar8x8 = (npred == dr);
      tick();
      fb_luma4x4    = 1'b0;
      fb_chromab8x8 = 1'b0;
      fb_chromar8x8 = 1'b0;
      npred++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got 1 want 0");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    int bad;

    tbl[0] = '{1,  1,  1, 2, 1'b1, 32'd0, 32'd0};
    tbl[1] = '{3, -1, -1, 4, 1'b0, 32'd1, 32'd1};
    tbl[2] = '{1, -1, -1, 2, 1'b0, 32'd2, 32'd1};
    tbl[3] = '{0, -1, -1, 1, 1'b0, 32'd3, 32'd1};
    tbl[4] = '{1,  5,  5, 6, 1'b1, 32'd4, 32'd1};
    tbl[5] = '{2, -1, -1, 3, 1'b0, 32'd5, 32'd2};
    tbl[6] = '{0,  0,  0, 1, 1'b0, 32'd6, 32'd2};
    tbl[7] = '{4,  0, -1, 5, 1'b0, 32'd7, 32'd2};

    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    blk_valid = 1'b0;
    fb_luma4x4 = 1'b0;
    fb_chromab8x8 = 1'b0;
    fb_chromar8x8 = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_flags",
        {24'd0, busy, blk_ready, step_done, frame_done,
         timeout_err, chroma_step, enabler == 3'b000, 1'b0},
        32'h2);
    chk("rst_luma", mbnumber_luma4x4, 32'd0);
    chk("rst_chroma", mbnumber_chroma, 32'd0);

    // full frame driven from the vector table
    pulse_start();
    chk("start_busy", {30'd0, busy, blk_ready}, 32'd3);
    sd_cnt = 0;
    fd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      chk("v_luma", mbnumber_luma4x4, tbl[i].exp_l);
      chk("v_chroma", mbnumber_chroma, tbl[i].exp_c);
      chk("v_cstep", {31'd0, chroma_step}, {31'd0, tbl[i].cs});
      do_step(tbl[i].dl, tbl[i].db, tbl[i].dr, n);
      chk("v_pred_len", n, tbl[i].exp_pred);
      chk("v_wb", {28'd0, step_done, enabler}, 32'hC);
      chk("v_wb_luma", mbnumber_luma4x4, tbl[i].exp_l);
      tick();
      if (i < 7) begin
        chk("v_next_luma", mbnumber_luma4x4, tbl[i].exp_l + 32'd1);
        chk("v_next_chroma", mbnumber_chroma,
            tbl[i].exp_c + {31'd0, tbl[i].cs});
      end
    end
    chk("done_pulse", {30'd0, frame_done, busy}, 32'd2);
    tick();
    chk("wrap_luma", mbnumber_luma4x4, 32'd0);
    chk("wrap_chroma", mbnumber_chroma, 32'd0);
    chk("done_gone", {30'd0, frame_done, busy}, 32'd0);
    chk("step_done_cnt", sd_cnt, 32'd8);
    chk("frame_done_cnt", fd_cnt, 32'd1);

    // watchdog expiry: ChromaB never arrives on a chroma step
    pulse_start();
    do_step(0, -1, 0, n);
    chk("to_pred_len", n, 32'd64);
    chk("to_err", {31'd0, timeout_err}, 32'd1);
    chk("to_idle", {27'd0, busy, blk_ready, enabler}, 32'd0);
    pulse_abort();
    chk("to_err_abort_keep", {31'd0, timeout_err}, 32'd1);
    pulse_start();
    chk("to_err_cleared", {30'd0, timeout_err, busy}, 32'd1);

    // completion on the last watchdog cycle wins
    do_step(0, 63, 0, n);
    chk("edge_pred_len", n, 32'd64);
    chk("edge_wb", {28'd0, timeout_err, enabler}, 32'h4);
    tick();
    chk("edge_luma", mbnumber_luma4x4, 32'd1);
    pulse_abort();

    // abort in PRED with non-zero counters
    pulse_start();
    do_step(0, 0, 0, n);
    tick();
    chk("ab_pre_luma", mbnumber_luma4x4, 32'd1);
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    tick();
    tick();
    chk("ab_in_pred", {29'd0, enabler}, 32'd2);
    pulse_abort();
    chk("ab_pred_idle", {27'd0, busy, blk_ready, enabler}, 32'd0);
    chk("ab_pred_cnt", mbnumber_luma4x4 | mbnumber_chroma, 32'd0);
    fb_luma4x4 = 1'b1;
    fb_chromab8x8 = 1'b1;
    fb_chromar8x8 = 1'b1;
    tick();
    fb_luma4x4 = 1'b0;
    fb_chromab8x8 = 1'b0;
    fb_chromar8x8 = 1'b0;
    tick();
    chk("ab_late_fb", {27'd0, busy, step_done, enabler}, 32'd0);

    // abort in NPWAIT
    pulse_start();
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    tick();
    chk("ab_in_npwait", {28'd0, busy, enabler}, 32'h8);
    pulse_abort();
    chk("ab_np_idle", {27'd0, busy, blk_ready, enabler}, 32'd0);
    pulse_start();
    do_step(2, 2, 2, n);
    chk("ab_after_len", n, 32'd3);
    pulse_abort();

    // READY stall, stray fb and start while busy
    pulse_start();
    do_step(0, 0, 0, n);
    tick();
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      fb_luma4x4 = (k == 3);
      fb_chromab8x8 = (k == 3);
      fb_chromar8x8 = (k == 3);
      start = (k == 5);
      tick();
      fb_luma4x4 = 1'b0;
      fb_chromab8x8 = 1'b0;
      fb_chromar8x8 = 1'b0;
      start = 1'b0;
      if (!(blk_ready && busy && enabler == 3'b000)) bad++;
    end
    chk("stall_ready", bad, 32'd0);
    chk("stall_luma", mbnumber_luma4x4, 32'd1);
    do_step(2, -1, -1, n);
    chk("stall_pred_len", n, 32'd3);
    tick();
    chk("stall_next_luma", mbnumber_luma4x4, 32'd2);
    pulse_abort();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
